spram_cmd_engine: RTL and testbench

SPRAM_CMD_ENGINE -- requirements
Module: spram_cmd_engine

---
 rtl/spram_cmd_engine.sv | 124 ++++++++++++
 tb/tb_spram_cmd_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spram_cmd_engine.sv
// spram_cmd_engine: SPI byte-command front end driving one SB_SPRAM256KA.
// Opcode 0x02 writes and 0x03 reads auto-incrementing 16-bit words, low byte first.
module spram_cmd_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [7:0]  tx_byte,
  output logic        mem_cs,
  output logic        mem_wren,
  output logic [3:0]  mem_maskwren,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        frame_err
);
  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA, DISCARD} state_t;
  state_t state, state_n;
  logic [13:0] addr;
  logic [7:0]  lo;
  logic [15:0] stage;
  logic        have_lo, is_rd, phase, rd_q, ld_tx;
  logic        take, fin, known;
  // a byte arriving alongside chip-select release is still consumed before the frame ends
  always_comb begin
    take = rx_valid && (cs_active || state != IDLE);
    fin = !take && !cs_active && state != IDLE;
    known = rx_byte == 8'h02 || rx_byte == 8'h03;
    state_n = state;
    if (fin) state_n = IDLE;
    else if (take)
      case (state)
        IDLE:    state_n = known ? ADDR_HI : DISCARD;
        ADDR_HI: state_n = ADDR_LO;
        ADDR_LO: state_n = is_rd ? RD_DATA : WR_DATA;
        default: state_n = state;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      lo <= '0;
      stage <= '0;
      have_lo <= 1'b0;
      is_rd <= 1'b0;
      phase <= 1'b0;
      rd_q <= 1'b0;
      ld_tx <= 1'b0;
      tx_byte <= '0;
      mem_cs <= 1'b0;
      mem_wren <= 1'b0;
      mem_maskwren <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      mem_cs <= 1'b0;
      mem_wren <= 1'b0;
      mem_maskwren <= '0;
      rd_q <= mem_cs && !mem_wren;
      // read data lands the cycle after the access; only the frame's first word goes straight out
      if (rd_q) begin
        stage <= mem_rdata;
        ld_tx <= 1'b0;
        if (ld_tx && state == RD_DATA) tx_byte <= mem_rdata[7:0];
      end
      if (fin) begin
        tx_byte <= '0;
        have_lo <= 1'b0;
        ld_tx <= 1'b0;
        if (state == WR_DATA && have_lo) begin
          mem_cs <= 1'b1;
          mem_wren <= 1'b1;
          mem_maskwren <= 4'b0011;
          mem_addr <= addr;
          mem_wdata <= {8'h00, lo};
        end
      end else if (take)
        case (state)
          IDLE: begin
            frame_err <= !known;
            is_rd <= rx_byte == 8'h03;
          end
          ADDR_HI: addr[13:8] <= rx_byte[5:0];
          ADDR_LO: begin
            addr[7:0] <= rx_byte;
            have_lo <= 1'b0;
            phase <= 1'b0;
            if (is_rd) begin
              mem_cs <= 1'b1;
              mem_addr <= {addr[13:8], rx_byte};
              ld_tx <= 1'b1;
            end
          end
          WR_DATA:
            if (!have_lo) begin
              lo <= rx_byte;
              have_lo <= 1'b1;
            end else begin
              mem_cs <= 1'b1;
              mem_wren <= 1'b1;
              mem_maskwren <= 4'b1111;
              mem_addr <= addr;
              mem_wdata <= {rx_byte, lo};
              addr <= addr + 14'd1;
              have_lo <= 1'b0;
            end
          RD_DATA: begin
            phase <= !phase;
            tx_byte <= phase ? stage[7:0] : stage[15:8];
            if (!phase) begin
              mem_cs <= 1'b1;
              mem_addr <= addr + 14'd1;
              addr <= addr + 14'd1;
            end
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_spram_cmd_engine.sv
// tb_spram_cmd_engine: directed frames against spram_cmd_engine with a behavioural SPRAM.
module tb_spram_cmd_engine;
  logic        clk = 1'b0, rst = 1'b1, cs_active = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic [7:0]  tx_byte;
  logic        mem_cs, mem_wren, frame_err;
  logic [3:0]  mem_maskwren;
  logic [13:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  int n_run = 0, n_fail = 0, n_acc = 0, bad_pulse = 0, base;
  logic prev_cs = 1'b0;
  logic [13:0] la [64];
  logic [15:0] ld [64];
  logic [3:0]  lm [64];
  logic [15:0] mem [16384];
  logic [15:0] m;

  spram_cmd_engine dut (
    .clk(clk), .rst(rst), .cs_active(cs_active), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_byte(tx_byte), .mem_cs(mem_cs), .mem_wren(mem_wren), .mem_maskwren(mem_maskwren),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  assign m = {{4{mem_maskwren[3]}}, {4{mem_maskwren[2]}}, {4{mem_maskwren[1]}}, {4{mem_maskwren[0]}}};
  always @(posedge clk)
    if (mem_cs) begin
      if (mem_wren) mem[mem_addr] <= (mem[mem_addr] & ~m) | (mem_wdata & m);
      else mem_rdata <= mem[mem_addr];
    end

  always @(negedge clk) begin
    if (mem_cs) begin
      if (n_acc < 64) begin
        la[n_acc] <= mem_addr;
        ld[n_acc] <= mem_wdata;
        lm[n_acc] <= mem_wren ? mem_maskwren : 4'h0;
      end
      n_acc <= n_acc + 1;
    end
    if ((mem_cs && prev_cs) || (!mem_cs && (mem_wren || mem_maskwren != 4'h0))) bad_pulse <= bad_pulse + 1;
    prev_cs <= mem_cs;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic gap;
    repeat (8) @(negedge clk);
  endtask

  task automatic sg(input logic [7:0] b);
    send(b); gap;
  endtask

  task automatic rd(input logic [7:0] b, input logic [7:0] exp, input string tag);
    send(b);
    repeat (2) @(posedge clk);
    #1 chk(tag, tx_byte, exp);
    gap;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_byte, 8'h00);
    chk("rst_cs", {mem_cs, mem_wren, mem_maskwren}, 6'h00);
    chk("rst_addr", mem_addr, 14'h0);
    chk("rst_wdata", mem_wdata, 16'h0);
    chk("rst_err", frame_err, 1'b0);
    rst = 1'b0;
    gap;
    sg(8'h7E);
    chk("ignored_no_cs_err", frame_err, 1'b0);
    chk("ignored_no_cs_acc", n_acc, 0);
    // write 0x1234 @0x0010, 0x5678 @0x0011
    cs_active = 1'b1;
    sg(8'h02); sg(8'h00); sg(8'h10); sg(8'h34);
    chk("wr_tx_zero", tx_byte, 8'h00);
    send(8'h12);
    chk("wr_cs_timing", {mem_cs, mem_wren, mem_maskwren}, 6'h3F);
    gap;
    sg(8'h78); sg(8'h56);
    cs_active = 1'b0;
    gap;
    chk("wr_count", n_acc, 2);
    chk("wr0_addr", la[0], 14'h0010);
    chk("wr0_data", ld[0], 16'h1234);
    chk("wr0_mask", lm[0], 4'hF);
    chk("wr1_addr", la[1], 14'h0011);
    chk("wr1_data", ld[1], 16'h5678);
    // read back
    cs_active = 1'b1;
    sg(8'h03); sg(8'h00);
    send(8'h10);
    chk("rd_issue", {mem_cs, mem_wren, mem_addr}, {2'b10, 14'h0010});
    repeat (2) @(posedge clk);
    #1 chk("rd_b0", tx_byte, 8'h34);
    gap;
    rd(8'h00, 8'h12, "rd_b1");
    rd(8'h00, 8'h78, "rd_b2");
    rd(8'h00, 8'h56, "rd_b3");
    cs_active = 1'b0;
    gap;
    chk("rd_end_tx", tx_byte, 8'h00);
    // wrap write with odd trailing byte
    base = n_acc;
    cs_active = 1'b1;
    sg(8'h02); sg(8'h3F); sg(8'hFF); sg(8'hAA); sg(8'hBB); sg(8'hCC);
    cs_active = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_count", n_acc - base, 2);
    chk("wrap0_addr", la[base], 14'h3FFF);
    chk("wrap0_data", ld[base], 16'hBBAA);
    chk("wrap0_mask", lm[base], 4'hF);
    chk("flush_addr", la[base+1], 14'h0000);
    chk("flush_data", ld[base+1][7:0], 8'hCC);
    chk("flush_mask", lm[base+1], 4'h3);
    gap;
    // unknown opcode
    cs_active = 1'b1;
    sg(8'h7E);
    chk("err_set", frame_err, 1'b1);
    base = n_acc;
    sg(8'h01); sg(8'h02);
    chk("err_tx", tx_byte, 8'h00);
    cs_active = 1'b0;
    gap;
    chk("err_no_acc", n_acc, base);
    chk("err_held", frame_err, 1'b1);
    // next frame clears error; read across the wrap
    cs_active = 1'b1;
    sg(8'h03);
    chk("err_clear", frame_err, 1'b0);
    sg(8'h3F);
    rd(8'hFF, 8'hAA, "wrap_rd0");
    rd(8'h00, 8'hBB, "wrap_rd1");
    chk("prefetch_wrap_addr", la[n_acc-1], 14'h0000);
    rd(8'h00, 8'hCC, "wrap_rd2");
    cs_active = 1'b0;
    gap;
    // reset mid-frame
    cs_active = 1'b1;
    sg(8'h02); sg(8'h00); sg(8'h05); sg(8'hEF); sg(8'hBE);
    cs_active = 1'b0;
    gap;
    base = n_acc;
    cs_active = 1'b1;
    sg(8'h03); sg(8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", tx_byte, 8'h00);
    chk("rstmid_cs", mem_cs, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cs_active = 1'b0;
    gap;
    chk("rstmid_no_acc", n_acc, base);
    cs_active = 1'b1;
    sg(8'h03); sg(8'h00);
    rd(8'h05, 8'hEF, "post_rst_rd0");
    rd(8'h00, 8'hBE, "post_rst_rd1");
    cs_active = 1'b0;
    gap;
    chk("cs_pulse_rules", bad_pulse, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
